// File: rtl/vga_sram_pkg.sv
// Shared types for the VGA/CPU SRAM arbiter.
// Latency: none (types, constants and a pure helper only).
// Backpressure: n/a.
package vga_sram_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
  typedef enum logic {OWN_VGA, OWN_CPU} arb_owner_t;

  // Encoding of the VGA controller's active-display state.
  localparam logic [1:0] VGA_ACTIVE = 2'd2;

  // Turns a VGA controller state into the arbiter's vga_active input.
  function automatic logic is_vga_active(input logic [1:0] vga_state);
    return vga_state == VGA_ACTIVE;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count updates one cycle after clr/inc.
// Backpressure: none; holds at MAX while inc stays high.
// Ports: clk, nrst (async active-low), clr, inc, count[W-1:0].
module arb_sat_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/vga_sram_arbiter.sv
// Shares one SRAM port between the VGA fetcher and the CPU; one access at a time.
// Latency: request seen in IDLE at N -> strobe at N+1 -> ack at N+3 minimum; aborts after TIMEOUT WAIT cycles.
// Backpressure: requesters hold req until their one-cycle ack; sram_busy stretches WAIT.
// Ports: VGA req/ack (vga_read, vga_address, vga_data, vga_ack), CPU req/ack
// (cpu_read/write, address, wdata, byte_sel, cpu_rdata, cpu_ack), timeout_err,
// SRAM command side (sram_read/write strobes, address, wdata, byte_sel, rdata, busy).
module vga_sram_arbiter
  import vga_sram_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        vga_active,
  input  logic        vga_read,
  input  logic [31:0] vga_address,
  output logic [31:0] vga_data,
  output logic        vga_ack,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byte_sel,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        timeout_err,
  output logic        sram_read,
  output logic        sram_write,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_byte_sel,
  input  logic [31:0] sram_rdata,
  input  logic        sram_busy
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int WAIT_W   = $clog2(TIMEOUT);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  arb_state_t          state;
  arb_owner_t          owner;
  logic                is_write;
  logic [STARVE_W-1:0] starve_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  logic cpu_req;
  logic cpu_want;
  logic vga_want;
  logic starve_full;
  logic in_wait;
  logic grant_vga;
  logic grant_cpu;

  assign cpu_req     = cpu_read | cpu_write;
  // A requester being acked this cycle still shows its old request; mask it.
  assign cpu_want    = cpu_req & ~cpu_ack;
  assign vga_want    = vga_read & ~vga_ack;
  assign starve_full = (starve_cnt == STARVE_MAX);
  assign in_wait     = (state == ARB_WAIT);

  // During active display a masked (just-acked) VGA request still blocks the
  // CPU, so the CPU only gets in through the starvation limit. Outside active
  // display the mask lets VGA in on the CPU's ack cycle.
  always_comb begin
    grant_vga = 1'b0;
    grant_cpu = 1'b0;
    if (state == ARB_IDLE) begin
      if (vga_active) begin
        if (cpu_want && starve_full) begin
          grant_cpu = 1'b1;
        end else if (vga_read) begin
          grant_vga = vga_want;
        end else begin
          grant_cpu = cpu_want;
        end
      end else begin
        if (cpu_want) begin
          grant_cpu = 1'b1;
        end else begin
          grant_vga = vga_want;
        end
      end
    end
  end

  // Starvation counts VGA grants taken while the CPU is asking at all (raw
  // request), so a VGA grant on the CPU's own ack cycle also counts.
  arb_sat_counter #(.MAX(STARVE_LIMIT), .W(STARVE_W)) u_starve (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (grant_cpu | ~cpu_req),
    .inc   (grant_vga & cpu_req),
    .count (starve_cnt)
  );

  // Zero on the first WAIT cycle; reaches TIMEOUT-1 on the last allowed one.
  arb_sat_counter #(.MAX(TIMEOUT - 1), .W(WAIT_W)) u_wait (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (~in_wait),
    .inc   (in_wait),
    .count (wait_cnt)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= ARB_IDLE;
      owner         <= OWN_VGA;
      is_write      <= 1'b0;
      sram_read     <= 1'b0;
      sram_write    <= 1'b0;
      sram_address  <= '0;
      sram_wdata    <= '0;
      sram_byte_sel <= '0;
      vga_ack       <= 1'b0;
      vga_data      <= '0;
      cpu_ack       <= 1'b0;
      cpu_rdata     <= '0;
      timeout_err   <= 1'b0;
    end else begin
      vga_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_cpu) begin
            owner         <= OWN_CPU;
            is_write      <= cpu_write;
            sram_address  <= cpu_address;
            sram_wdata    <= cpu_wdata;
            sram_byte_sel <= cpu_byte_sel;
            sram_read     <= ~cpu_write;   // read+write together is a write
            sram_write    <= cpu_write;
            state         <= ARB_ISSUE;
          end else if (grant_vga) begin
            owner         <= OWN_VGA;
            is_write      <= 1'b0;
            sram_address  <= vga_address;
            sram_wdata    <= '0;
            sram_byte_sel <= 4'hF;
            sram_read     <= 1'b1;
            sram_write    <= 1'b0;
            state         <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          sram_read  <= 1'b0;
          sram_write <= 1'b0;
          state      <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // Completion takes priority over the timeout on the same cycle.
          if (!sram_busy || (wait_cnt == WAIT_LAST)) begin
            state       <= ARB_IDLE;
            timeout_err <= sram_busy;
            if (owner == OWN_VGA) begin
              vga_ack  <= 1'b1;
              vga_data <= sram_busy ? 32'h0 : sram_rdata;
            end else begin
              cpu_ack <= 1'b1;
              if (sram_busy) begin
                cpu_rdata <= 32'h0;
              end else if (!is_write) begin
                cpu_rdata <= sram_rdata;
              end
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
